// File: rtl/intr_ctrl_if.sv
// rtl/intr_ctrl_if.sv - register window, irq lines and CP0 request/ack bundle for intr_ctrl
interface intr_ctrl_if #(
    parameter int N_SRC = 6
);
    logic [1:0]       addr;
    logic             we;
    logic [31:0]      datai;
    logic [31:0]      datao;
    logic [N_SRC-1:0] irq_in;
    logic             int_req;
    logic [3:0]       int_id;
    logic             int_ack;

    modport master (
        output addr, we, datai, irq_in, int_ack,
        input  datao, int_req, int_id
    );

    modport slave (
        input  addr, we, datai, irq_in, int_ack,
        output datao, int_req, int_id
    );
endinterface

// File: rtl/intr_ctrl.sv
// rtl/intr_ctrl.sv - edge/level interrupt controller with priority encode and EOI; optional IRQ_SYNC_EN input synchronizer
module intr_ctrl #(
    parameter int N_SRC = 6
) (
    input  logic       clk,
    input  logic       reset,
    intr_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, SVC} state_t;

    state_t           state, next_state;
    logic [N_SRC-1:0] s, prev, pend_lat, mask_r, mode_r;
    logic [N_SRC-1:0] pend_eff, elig, set_ev, clr_w1c, clr_ack;
    logic [3:0]       isr_id, id;
    logic             ack_take, eoi_take;
    logic             wr_pend, wr_mask, wr_mode, wr_isr;
    logic             unused_datai;

    assign unused_datai = &{1'b0, bus.datai[31:N_SRC]};

`ifdef IRQ_SYNC_EN
    logic [N_SRC-1:0] sync1, sync2;

    // Two-flop synchronizer on the raw device lines
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bus.irq_in;
            sync2 <= sync1;
        end
    end

    assign s = sync2;
`else
    assign s = bus.irq_in;
`endif

    assign wr_pend = bus.we && (bus.addr == 2'd0);
    assign wr_mask = bus.we && (bus.addr == 2'd1);
    assign wr_mode = bus.we && (bus.addr == 2'd2);
    assign wr_isr  = bus.we && (bus.addr == 2'd3);

    // Only edge-mode sources ever store a pending bit
    assign set_ev   = s & ~prev & mode_r;
    assign clr_w1c  = wr_pend ? bus.datai[N_SRC-1:0] : '0;
    assign pend_eff = (pend_lat & mode_r) | (s & ~mode_r);
    assign elig     = pend_eff & mask_r;

    // Lowest set index wins; scanning down leaves the smallest one in id
    always_comb begin
        id = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (elig[i]) id = 4'(i);
        end
    end

    // One-hot clear of the source being accepted by CP0
    always_comb begin
        clr_ack = '0;
        for (int i = 0; i < N_SRC; i++) begin
            clr_ack[i] = ack_take && (id == 4'(i));
        end
    end

    // Edge history and latched pending bits; a new edge beats any same-cycle clear
    always_ff @(posedge clk) begin
        if (reset) begin
            prev     <= '0;
            pend_lat <= '0;
        end else begin
            prev     <= s;
            pend_lat <= ((pend_lat & ~(clr_w1c | clr_ack)) | set_ev) & mode_r;
        end
    end

    // MASK and MODE configuration registers
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_r <= '0;
            mode_r <= '0;
        end else begin
            if (wr_mask) mask_r <= bus.datai[N_SRC-1:0];
            if (wr_mode) mode_r <= bus.datai[N_SRC-1:0];
        end
    end

    // In-service id: captured on ack, dropped on EOI so ISR reads back zero
    always_ff @(posedge clk) begin
        if (reset) begin
            isr_id <= '0;
        end else if (ack_take) begin
            isr_id <= id;
        end else if (eoi_take) begin
            isr_id <= '0;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // FSM next state; ack only counts in REQ, EOI only counts in SVC
    always_comb begin
        next_state = state;
        ack_take   = 1'b0;
        eoi_take   = 1'b0;
        case (state)
            IDLE: begin
                if (elig != '0) next_state = REQ;
            end
            REQ: begin
                if (bus.int_ack) begin
                    ack_take   = 1'b1;
                    next_state = SVC;
                end else if (elig == '0) begin
                    next_state = IDLE;
                end
            end
            SVC: begin
                if (wr_isr) begin
                    eoi_take   = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign bus.int_req = (state == REQ);
    assign bus.int_id  = id;

    // Combinational read mux; unused high bits read zero
    always_comb begin
        bus.datao = '0;
        case (bus.addr)
            2'd0: bus.datao = 32'(pend_eff);
            2'd1: bus.datao = 32'(mask_r);
            2'd2: bus.datao = 32'(mode_r);
            2'd3: bus.datao = {(state == SVC), 27'b0, isr_id};
            default: bus.datao = '0;
        endcase
    end
endmodule

// File: tb/tb_intr_ctrl.sv
// tb/tb_intr_ctrl.sv - directed vector bench for intr_ctrl
module tb_intr_ctrl;
    localparam int N_SRC = 6;
`ifdef IRQ_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    logic reset;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    intr_ctrl_if #(.N_SRC(N_SRC)) bus ();

    intr_ctrl #(.N_SRC(N_SRC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        we;
        logic [1:0]  waddr;
        logic [31:0] wdata;
        logic [5:0]  irq;
        logic        ack;
        logic [1:0]  raddr;
        logic        exp_req;
        logic [3:0]  exp_id;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic we, input logic [1:0] waddr, input logic [31:0] wdata,
                                input logic [5:0] irq, input logic ack, input logic [1:0] raddr,
                                input logic exp_req, input logic [3:0] exp_id, input logic [31:0] exp_data);
        vec_t v;
        v.we = we; v.waddr = waddr; v.wdata = wdata; v.irq = irq; v.ack = ack;
        v.raddr = raddr; v.exp_req = exp_req; v.exp_id = exp_id; v.exp_data = exp_data;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic read_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
        bus.addr = a;
        #1;
        chk(name, bus.datao, exp);
    endtask

    initial begin
        int n;
        bus.addr = '0; bus.we = 1'b0; bus.datai = '0; bus.irq_in = '0; bus.int_ack = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        chk("reset int_req", 32'(bus.int_req), 32'h0);
        chk("reset int_id", 32'(bus.int_id), 32'h0);
        read_chk("reset isr", 2'd3, 32'h0);

`ifndef IRQ_SYNC_EN
        //   we waddr wdata         irq    ack rd  req id  data
        add(1, 2'd1, 32'h3F,        6'h00, 0, 2'd1, 0, 0, 32'h3F);
        add(1, 2'd2, 32'h3F,        6'h00, 0, 2'd2, 0, 0, 32'h3F);
        add(0, 2'd0, 32'h0,         6'h04, 0, 2'd0, 0, 2, 32'h4);
        add(0, 2'd0, 32'h0,         6'h00, 0, 2'd0, 1, 2, 32'h4);
        add(0, 2'd0, 32'h0,         6'h00, 1, 2'd3, 0, 0, 32'h8000_0002);
        add(0, 2'd0, 32'h0,         6'h00, 0, 2'd0, 0, 0, 32'h0);
        add(1, 2'd3, 32'h0,         6'h00, 0, 2'd3, 0, 0, 32'h0);
        add(0, 2'd0, 32'h0,         6'h00, 1, 2'd3, 0, 0, 32'h0);
        add(0, 2'd0, 32'h0,         6'h10, 0, 2'd0, 0, 4, 32'h10);
        add(0, 2'd0, 32'h0,         6'h00, 0, 2'd0, 1, 4, 32'h10);
        add(0, 2'd0, 32'h0,         6'h02, 0, 2'd0, 1, 1, 32'h12);
        add(0, 2'd0, 32'h0,         6'h00, 1, 2'd3, 0, 4, 32'h8000_0001);
        add(0, 2'd0, 32'h0,         6'h00, 0, 2'd0, 0, 4, 32'h10);
        add(1, 2'd3, 32'h0,         6'h00, 0, 2'd3, 0, 4, 32'h0);
        add(0, 2'd0, 32'h0,         6'h00, 0, 2'd0, 1, 4, 32'h10);
        add(0, 2'd0, 32'h0,         6'h00, 1, 2'd3, 0, 0, 32'h8000_0004);
        add(1, 2'd3, 32'h0,         6'h00, 0, 2'd3, 0, 0, 32'h0);
        add(1, 2'd2, 32'h0,         6'h00, 0, 2'd2, 0, 0, 32'h0);
        add(1, 2'd1, 32'h01,        6'h00, 0, 2'd1, 0, 0, 32'h1);
        add(0, 2'd0, 32'h0,         6'h01, 0, 2'd0, 1, 0, 32'h1);
        add(0, 2'd0, 32'h0,         6'h01, 0, 2'd0, 1, 0, 32'h1);
        add(0, 2'd0, 32'h0,         6'h00, 0, 2'd0, 0, 0, 32'h0);
        add(1, 2'd1, 32'h0,         6'h00, 0, 2'd1, 0, 0, 32'h0);
        add(1, 2'd2, 32'h3F,        6'h00, 0, 2'd2, 0, 0, 32'h3F);
        add(0, 2'd0, 32'h0,         6'h08, 0, 2'd0, 0, 0, 32'h8);
        add(0, 2'd0, 32'h0,         6'h00, 0, 2'd0, 0, 0, 32'h8);
        add(1, 2'd0, 32'h8,         6'h00, 0, 2'd0, 0, 0, 32'h0);
        add(1, 2'd0, 32'h8,         6'h08, 0, 2'd0, 0, 0, 32'h8);
        add(0, 2'd0, 32'h0,         6'h00, 0, 2'd0, 0, 0, 32'h8);
        add(1, 2'd1, 32'h3F,        6'h00, 0, 2'd1, 0, 3, 32'h3F);
        add(0, 2'd0, 32'h0,         6'h00, 0, 2'd0, 1, 3, 32'h8);
        add(1, 2'd0, 32'h8,         6'h00, 1, 2'd3, 0, 0, 32'h8000_0003);
        add(0, 2'd0, 32'h0,         6'h20, 0, 2'd0, 0, 5, 32'h20);
        add(0, 2'd0, 32'h0,         6'h00, 0, 2'd3, 0, 5, 32'h8000_0003);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            bus.we = vecs[i].we; bus.addr = vecs[i].waddr; bus.datai = vecs[i].wdata;
            bus.irq_in = vecs[i].irq; bus.int_ack = vecs[i].ack;
            @(posedge clk);
            #1;
            bus.we = 1'b0; bus.int_ack = 1'b0; bus.addr = vecs[i].raddr;
            #1;
            chk($sformatf("v%0d int_req", i), 32'(bus.int_req), 32'(vecs[i].exp_req));
            chk($sformatf("v%0d int_id", i), 32'(bus.int_id), 32'(vecs[i].exp_id));
            chk($sformatf("v%0d datao", i), bus.datao, vecs[i].exp_data);
        end
`else
        // Put the controller into service so the reset below lands mid-service
        @(negedge clk);
        bus.we = 1'b1; bus.addr = 2'd1; bus.datai = 32'h3F;
        @(negedge clk);
        bus.addr = 2'd2;
        @(negedge clk);
        bus.we = 1'b0; bus.irq_in = 6'h20;
        n = 0;
        while (!bus.int_req && n < 10) begin
            @(posedge clk); #1; n++;
        end
        chk("sync reach REQ", 32'(bus.int_req), 32'h1);
        @(negedge clk);
        bus.int_ack = 1'b1; bus.irq_in = 6'h00;
        @(negedge clk);
        bus.int_ack = 1'b0;
        read_chk("sync isr svc", 2'd3, 32'h8000_0005);
`endif

        // Reset while in service clears every register and the request
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        chk("rst int_req", 32'(bus.int_req), 32'h0);
        chk("rst int_id", 32'(bus.int_id), 32'h0);
        read_chk("rst pend", 2'd0, 32'h0);
        read_chk("rst mask", 2'd1, 32'h0);
        read_chk("rst mode", 2'd2, 32'h0);
        read_chk("rst isr", 2'd3, 32'h0);

        // Edge latency from irq_in rise to int_req after reset
        @(negedge clk);
        bus.we = 1'b1; bus.addr = 2'd1; bus.datai = 32'h3F;
        @(negedge clk);
        bus.addr = 2'd2;
        @(negedge clk);
        bus.we = 1'b0; bus.irq_in = 6'h04;
        n = 0;
        while (!bus.int_req && n < 10) begin
            @(posedge clk); #1; n++;
            bus.irq_in = 6'h00;
        end
        chk("latency", 32'(n), 32'(LAT));
        chk("latency int_id", 32'(bus.int_id), 32'h2);
        read_chk("latency pend", 2'd0, 32'h4);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
